leitor_tabuleiro: RTL and testbench

- Reads back the ultimate tic-tac-toe board memories, which the game datapath only writes, and streams their contents out as a paced word sequence.
- Inputs: the 81 micro cells (cell RAM, 2-bit, synchronous read) and the 9 macro states (state RAM, 2-bit, synchronous read).
- Each read word goes to a downstream consumer (serial transmitter / display driver) over a valid/ready handshake.
- Also reports how many micro cells were occupied in the last complete scan.

---
 rtl/leitor_tabuleiro.sv | 162 ++++++++++++++++
 tb/tb_leitor_tabuleiro.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leitor_tabuleiro.sv
// Board read-back streamer for ultimate tic-tac-toe.
// Walks the cell RAM (micro index inner, macro index outer) and optionally the
// macro-state RAM. Each word it reads goes out over a valid/ready handshake.
// It also counts the occupied cells seen during the last complete scan.
//
// state   | meaning
// --------+-----------------------------------------------------------
// OCIOSO  | idle, waiting for iniciar; addresses hold last value
// LE      | address presented to the RAMs
// ESPERA  | RAM data valid, captured into dado with its tags
// ENVIA   | valido high, waiting for pronto_rx
// PROXIMO | advance indices (micro inner, macro outer, then state phase)
// FIM     | one-cycle fim pulse, publish occupied-cell count
module leitor_tabuleiro #(
  parameter int N_MACRO       = 9,
  parameter int N_MICRO       = 9,
  parameter bit INCLUI_ESTADO = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [1:0] q_micro,
  input  logic [1:0] q_macro,
  output logic [3:0] addr_macro,
  output logic [3:0] addr_micro,
  output logic [1:0] dado,
  output logic [3:0] dado_macro,
  output logic [3:0] dado_micro,
  output logic       dado_tipo,
  output logic       valido,
  input  logic       pronto_rx,
  output logic       ocupado,
  output logic       fim,
  output logic [6:0] n_ocupadas
);

  localparam logic [3:0] ULT_MACRO = 4'(N_MACRO - 1);
  localparam logic [3:0] ULT_MICRO = 4'(N_MICRO - 1);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    LE      = 3'd1,
    ESPERA  = 3'd2,
    ENVIA   = 3'd3,
    PROXIMO = 3'd4,
    FIM     = 3'd5
  } estado_t;

  estado_t    r_estado;
  estado_t    w_proximo;
  logic [3:0] r_macro;
  logic [3:0] r_micro;
  logic       r_fase;        // 0 = cell phase, 1 = macro-state phase
  logic [6:0] r_acum;
  logic [1:0] r_dado;
  logic [3:0] r_dado_macro;
  logic [3:0] r_dado_micro;
  logic       r_dado_tipo;
  logic [6:0] r_n_ocupadas;
  logic       w_valido;
  logic       w_ocupado;
  logic       w_fim;
  logic       w_fim_varredura;

  // Last word of the scan: last state word, or last cell when states are excluded
  assign w_fim_varredura = r_fase ? (r_macro == ULT_MACRO)
                                  : ((r_micro == ULT_MICRO) && (r_macro == ULT_MACRO) && !INCLUI_ESTADO);

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_estado <= OCIOSO;
    else       r_estado <= w_proximo;
  end

  // Next-state and handshake/status outputs
  always_comb begin
    w_proximo = r_estado;
    w_valido  = 1'b0;
    w_ocupado = 1'b1;
    w_fim     = 1'b0;
    case (r_estado)
      OCIOSO: begin
        w_ocupado = 1'b0;
        if (iniciar) w_proximo = LE;
      end
      LE:      w_proximo = ESPERA;
      ESPERA:  w_proximo = ENVIA;
      ENVIA: begin
        w_valido = 1'b1;
        if (pronto_rx) w_proximo = PROXIMO;
      end
      PROXIMO: w_proximo = w_fim_varredura ? FIM : LE;
      FIM: begin
        w_fim     = 1'b1;
        w_proximo = OCIOSO;
      end
      default: w_proximo = OCIOSO;
    endcase
  end

  // Scan indices, captured word, occupancy accumulator and published count
  always_ff @(posedge clock) begin
    if (reset) begin
      r_macro      <= '0;
      r_micro      <= '0;
      r_fase       <= 1'b0;
      r_acum       <= '0;
      r_dado       <= '0;
      r_dado_macro <= '0;
      r_dado_micro <= '0;
      r_dado_tipo  <= 1'b0;
      r_n_ocupadas <= '0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (iniciar) begin
            r_macro <= '0;
            r_micro <= '0;
            r_fase  <= 1'b0;
            r_acum  <= '0;
          end
        end
        ESPERA: begin
          r_dado       <= r_fase ? q_macro : q_micro;
          r_dado_macro <= r_macro;
          r_dado_micro <= r_fase ? 4'd0 : r_micro;
          r_dado_tipo  <= r_fase;
          if (!r_fase && (q_micro != 2'b00)) r_acum <= r_acum + 7'd1;
        end
        PROXIMO: begin
          if (r_fase) begin
            if (r_macro != ULT_MACRO) r_macro <= r_macro + 4'd1;
          end else if (r_micro != ULT_MICRO) begin
            r_micro <= r_micro + 4'd1;
          end else begin
            r_micro <= '0;
            if (r_macro != ULT_MACRO) begin
              r_macro <= r_macro + 4'd1;
            end else if (INCLUI_ESTADO) begin
              r_fase  <= 1'b1;
              r_macro <= '0;
            end
          end
        end
        FIM: r_n_ocupadas <= r_acum;
        default: ;
      endcase
    end
  end

  assign addr_macro = r_macro;
  assign addr_micro = r_fase ? 4'd0 : r_micro;
  assign dado       = r_dado;
  assign dado_macro = r_dado_macro;
  assign dado_micro = r_dado_micro;
  assign dado_tipo  = r_dado_tipo;
  assign valido     = w_valido;
  assign ocupado    = w_ocupado;
  assign fim        = w_fim;
  assign n_ocupadas = r_n_ocupadas;

endmodule

// File: tb/tb_leitor_tabuleiro.sv
// Directed bench for leitor_tabuleiro: dut0 uses default parameters, dut1 has
// INCLUI_ESTADO=0. Both share clock, reset, iniciar, pronto_rx and RAM contents.
// Edge numbering: edge 0 is the edge that samples iniciar; e = n means the value
// observed just after edge n (so the first valido shows at e=2 and a consumer
// registers it at edge 3; fim shows at e=360, or e=324 without state words).
module tb_leitor_tabuleiro;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       pronto_rx = 1'b1;

  logic [1:0] q_micro0, q_macro0, q_micro1, q_macro1;
  logic [3:0] addr_macro0, addr_micro0, addr_macro1, addr_micro1;
  logic [1:0] dado0, dado1;
  logic [3:0] dado_macro0, dado_micro0, dado_macro1, dado_micro1;
  logic       dado_tipo0, dado_tipo1, valido0, valido1;
  logic       ocupado0, ocupado1, fim0, fim1;
  logic [6:0] n_ocupadas0, n_ocupadas1;

  logic [1:0] cel [0:80];
  logic [1:0] est [0:8];
  logic [1:0] got [0:89];

  int checks = 0;
  int errors = 0;

  int words, seq_err, stab_err, fim_e, first_v_e, n_tipo1, n_fim;
  bit timeout;

  always #5 clock = ~clock;

  leitor_tabuleiro dut0 (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .q_micro(q_micro0), .q_macro(q_macro0),
    .addr_macro(addr_macro0), .addr_micro(addr_micro0),
    .dado(dado0), .dado_macro(dado_macro0), .dado_micro(dado_micro0),
    .dado_tipo(dado_tipo0), .valido(valido0), .pronto_rx(pronto_rx),
    .ocupado(ocupado0), .fim(fim0), .n_ocupadas(n_ocupadas0)
  );

  leitor_tabuleiro #(.INCLUI_ESTADO(1'b0)) dut1 (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .q_micro(q_micro1), .q_macro(q_macro1),
    .addr_macro(addr_macro1), .addr_micro(addr_micro1),
    .dado(dado1), .dado_macro(dado_macro1), .dado_micro(dado_micro1),
    .dado_tipo(dado_tipo1), .valido(valido1), .pronto_rx(pronto_rx),
    .ocupado(ocupado1), .fim(fim1), .n_ocupadas(n_ocupadas1)
  );

  function automatic int idx(input logic [3:0] ma, input logic [3:0] mi);
    if (ma < 4'd9 && mi < 4'd9) return int'(ma) * 9 + int'(mi);
    return 0;
  endfunction

  function automatic int eidx(input logic [3:0] ma);
    if (ma < 4'd9) return int'(ma);
    return 0;
  endfunction

  // Synchronous-read RAM models, one read port per DUT
  always @(posedge clock) begin
    q_micro0 <= cel[idx(addr_macro0, addr_micro0)];
    q_macro0 <= est[eidx(addr_macro0)];
    q_micro1 <= cel[idx(addr_macro1, addr_micro1)];
    q_macro1 <= est[eidx(addr_macro1)];
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Runs one scan on the selected DUT, gathering the transferred words and
  // timing into bench variables; the calling test compares them.
  task automatic scan(input bit sel, input int pct, input int ini_at, input int abort_at);
    int e;
    bit stall;
    logic v, f, tp, stp;
    logic [1:0] d, sd, ed;
    logic [3:0] ma, mi, sma, smi, ema, emi;
    words = 0; seq_err = 0; stab_err = 0; fim_e = -1; first_v_e = -1;
    n_tipo1 = 0; n_fim = 0; timeout = 0; stall = 0;
    sd = '0; sma = '0; smi = '0; stp = 1'b0;
    iniciar = 1'b1;
    pronto_rx = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    e = 0;
    while (1) begin
      v  = sel ? valido1 : valido0;
      f  = sel ? fim1 : fim0;
      d  = sel ? dado1 : dado0;
      ma = sel ? dado_macro1 : dado_macro0;
      mi = sel ? dado_micro1 : dado_micro0;
      tp = sel ? dado_tipo1 : dado_tipo0;
      if (v && first_v_e < 0) first_v_e = e;
      if (stall && (!v || d !== sd || ma !== sma || mi !== smi || tp !== stp)) stab_err++;
      if (f) begin
        n_fim++;
        if (fim_e < 0) fim_e = e;
      end
      iniciar = (e == ini_at);
      pronto_rx = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      if (v && pronto_rx) begin
        if (words < 81) begin
          ed = cel[words]; ema = 4'(words / 9); emi = 4'(words % 9);
          if (d !== ed || ma !== ema || mi !== emi || tp !== 1'b0) seq_err++;
        end else if (words < 90 && !sel) begin
          ed = est[words - 81]; ema = 4'(words - 81);
          if (d !== ed || ma !== ema || mi !== 4'd0 || tp !== 1'b1) seq_err++;
        end else begin
          seq_err++;
        end
        if (words < 90) got[words] = d;
        if (tp) n_tipo1++;
        words++;
      end
      stall = v && !pronto_rx;
      sd = d; sma = ma; smi = mi; stp = tp;
      if (abort_at >= 0 && words == abort_at) begin
        reset = 1'b1;
        iniciar = 1'b0;
        return;
      end
      if (f) break;
      if (e >= 3000) begin
        timeout = 1;
        break;
      end
      @(negedge clock);
      e++;
    end
    iniciar = 1'b0;
    pronto_rx = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(3);
    checks++;
    if ({valido0, ocupado0, fim0} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl got %b want 000", {valido0, ocupado0, fim0});
    end
    checks++;
    if ({dado0, dado_macro0, dado_micro0, dado_tipo0} !== 11'd0) begin
      errors++; $display("FAIL reset_dado got %h want 0", {dado0, dado_macro0, dado_micro0, dado_tipo0});
    end
    checks++;
    if ({addr_macro0, addr_micro0} !== 8'd0) begin
      errors++; $display("FAIL reset_addr got %h want 00", {addr_macro0, addr_micro0});
    end
    checks++;
    if (n_ocupadas0 !== 7'd0) begin
      errors++; $display("FAIL reset_nocup got %0d want 0", n_ocupadas0);
    end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_vazio;
    scan(0, 100, -1, -1);
    checks++;
    if (timeout || words != 90) begin
      errors++; $display("FAIL vazio_words got %0d (timeout %0d) want 90", words, timeout);
    end
    checks++;
    if (seq_err != 0) begin
      errors++; $display("FAIL vazio_seq got %0d bad words want 0", seq_err);
    end
    checks++;
    if (n_tipo1 != 9) begin
      errors++; $display("FAIL vazio_tipo1 got %0d want 9", n_tipo1);
    end
    checks++;
    if (first_v_e != 2) begin
      errors++; $display("FAIL vazio_first_valid got %0d want 2", first_v_e);
    end
    checks++;
    if (fim_e != 360 || n_fim != 1) begin
      errors++; $display("FAIL vazio_fim got e=%0d n=%0d want e=360 n=1", fim_e, n_fim);
    end
    idle(50);
    checks++;
    if (n_ocupadas0 !== 7'd0 || ocupado0 !== 1'b0) begin
      errors++; $display("FAIL vazio_nocup got %0d ocup %b want 0 0", n_ocupadas0, ocupado0);
    end
  endtask

  task automatic test_preload;
    cel[2*9+4] = 2'b01;
    cel[80]    = 2'b10;
    est[5]     = 2'b11;
    scan(0, 100, -1, -1);
    checks++;
    if (got[22] !== 2'b01 || got[80] !== 2'b10 || got[86] !== 2'b11) begin
      errors++; $display("FAIL preload_words got %b %b %b want 01 10 11", got[22], got[80], got[86]);
    end
    checks++;
    if (seq_err != 0 || words != 90) begin
      errors++; $display("FAIL preload_seq got %0d bad of %0d want 0 of 90", seq_err, words);
    end
    checks++;
    if (fim_e != 360) begin
      errors++; $display("FAIL preload_fim got %0d want 360", fim_e);
    end
    idle(50);
    checks++;
    if (n_ocupadas0 !== 7'd2) begin
      errors++; $display("FAIL preload_nocup got %0d want 2", n_ocupadas0);
    end
  endtask

  task automatic test_backpressure;
    scan(0, 30, -1, -1);
    checks++;
    if (timeout || words != 90 || seq_err != 0) begin
      errors++; $display("FAIL bp_seq got %0d words %0d bad want 90 0", words, seq_err);
    end
    checks++;
    if (stab_err != 0) begin
      errors++; $display("FAIL bp_stable got %0d unstable want 0", stab_err);
    end
    checks++;
    if (n_fim != 1 || fim_e <= 360) begin
      errors++; $display("FAIL bp_fim got n=%0d e=%0d want n=1 e>360", n_fim, fim_e);
    end
    idle(50);
    checks++;
    if (n_ocupadas0 !== 7'd2) begin
      errors++; $display("FAIL bp_nocup got %0d want 2", n_ocupadas0);
    end
  endtask

  task automatic test_iniciar_ignorado;
    scan(0, 100, 150, -1);
    checks++;
    if (words != 90 || seq_err != 0 || fim_e != 360 || n_fim != 1) begin
      errors++; $display("FAIL ini_ignored got w=%0d bad=%0d fim=%0d n=%0d want 90 0 360 1",
                         words, seq_err, fim_e, n_fim);
    end
    idle(50);
    scan(0, 100, -1, -1);
    checks++;
    if (words != 90 || seq_err != 0 || fim_e != 360) begin
      errors++; $display("FAIL ini_second got w=%0d bad=%0d fim=%0d want 90 0 360", words, seq_err, fim_e);
    end
    idle(50);
  endtask

  task automatic test_sem_estado;
    scan(1, 100, -1, -1);
    checks++;
    if (words != 81 || seq_err != 0) begin
      errors++; $display("FAIL noest_words got %0d bad %0d want 81 0", words, seq_err);
    end
    checks++;
    if (fim_e != 324 || n_tipo1 != 0) begin
      errors++; $display("FAIL noest_fim got e=%0d tipo1=%0d want 324 0", fim_e, n_tipo1);
    end
    idle(50);
    checks++;
    if (n_ocupadas1 !== 7'd2) begin
      errors++; $display("FAIL noest_nocup got %0d want 2", n_ocupadas1);
    end
  endtask

  task automatic test_reset_meio;
    int nf;
    scan(0, 100, -1, 40);
    @(negedge clock);
    checks++;
    if ({valido0, ocupado0, fim0} !== 3'b000) begin
      errors++; $display("FAIL abort_ctrl got %b want 000", {valido0, ocupado0, fim0});
    end
    checks++;
    if (n_ocupadas0 !== 7'd0) begin
      errors++; $display("FAIL abort_nocup got %0d want 0", n_ocupadas0);
    end
    reset = 1'b0;
    nf = 0;
    repeat (20) begin
      @(negedge clock);
      if (fim0 || ocupado0) nf++;
    end
    checks++;
    if (nf != 0) begin
      errors++; $display("FAIL abort_quiet got %0d active cycles want 0", nf);
    end
  endtask

  initial begin
    for (int i = 0; i < 81; i++) cel[i] = 2'b00;
    for (int i = 0; i < 9; i++) est[i] = 2'b00;
    for (int i = 0; i < 90; i++) got[i] = 2'b00;
    test_reset;
    test_vazio;
    test_preload;
    test_backpressure;
    test_iniciar_ignorado;
    test_sem_estado;
    test_reset_meio;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
